neuron_mac_scheduler: RTL
=========================

Name: neuron_mac_scheduler

Overview:
Time-multiplexes one sign-magnitude fixed-point multiplier (`qmult`) across the input/weight pairs of one neuron. It streams pairs in, accumulates the products in two's complement, and rescales by Q. The result is saturated back to N-bit sign-magnitude and handed to the CORDIC activation stage over a valid/ready handshake. It sits between the input/weight buffers and the activation block.

Parameters:
- N, 16, operand/result width, sign-magnitude (bit N-1 = sign, bits N-2:0 = magnitude)
- Q, 8, fractional bits of the operands and the result
- MAX_TERMS, 8, maximum pairs per neuron evaluation
- CNT_W, $clog2(MAX_TERMS+1), width of i_count (derived, localparam)

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  start pulse; sampled only in IDLE
- i_count  in  CNT_W  number of pairs for this evaluation, 0..MAX_TERMS; captured with i_start
- o_busy  out  1  high in any state other than IDLE
- i_valid  in  1  operand pair valid
- i_x  in  N  input activation, sign-magnitude Q format
- i_w  in  N  weight, sign-magnitude Q format
- o_ready  out  1  pair accepted on an edge where i_valid & o_ready
- o_valid  out  1  result valid
- o_result  out  N  neuron pre-activation sum, sign-magnitude Q format
- o_sat  out  1  result was saturated; qualified by o_valid
- i_ready  in  1  downstream accepts the result

Behaviour:
- Reset values: o_busy=0, o_ready=0, o_valid=0, o_result=0, o_sat=0. Accumulator, counters and pipeline valids are cleared and state=IDLE.
- Reset mid-operation aborts immediately; in-flight pairs are discarded with no residue in the next evaluation.
- States:
  - IDLE: i_start=1 captures i_count and clears the accumulator. Goes to ACCUM if i_count>0, else DRAIN. i_start outside IDLE is ignored.
  - ACCUM: o_ready = (accepted < count), combinational from registers. An accept registers i_x/i_w and increments accepted. Leaves to DRAIN after the edge accepting the last pair.
  - DRAIN: waits for the pipeline to empty (product stage valid clear), then registers the output and goes to OUTPUT.
  - OUTPUT: o_valid=1, with o_result and o_sat held stable until i_valid... i.e. until i_ready=1. The handshake edge goes to IDLE; o_valid drops the next cycle.
- Pipeline:
  - Edge k: pair accepted into operand registers.
  - Edge k+1: the `qmult` product {sign, 2N-1 magnitude bits} is converted to two's complement (negate if sign=1) and added to the accumulator.
  - Edge k+2 after the last accept: result registered; o_valid high.
  - With i_valid held high, throughput is one pair per cycle.
- Accumulator width: ACC_W = 2N + $clog2(MAX_TERMS) + 1, two's complement. It cannot wrap for any legal input.
- Negative zero: an operand with magnitude 0 and sign 1 produces a product of exactly +0.
- Output conversion:
  - sign = acc<0; mag = |acc| >> Q, truncating the magnitude toward zero.
  - If mag > 2^(N-1)-1, then mag = 2^(N-1)-1 and o_sat=1.
  - Zero magnitude forces sign=0; o_result is never -0.
- i_count=0: result 0x0000, o_sat=0, o_valid 2 cycles after start.
- i_count > MAX_TERMS: clamped to MAX_TERMS.
- The `qmult` ovr output is unused; saturation is decided only at the output stage.

Decomposition:
- Shared package `neuron_pkg`: N/Q defaults, MAG_MAX = 2^(N-1)-1, the state enum (IDLE, ACCUM, DRAIN, OUTPUT), and the sign-magnitude ↔ two's complement conversion functions (also used by the activation block).
- One sub-module: the existing `qmult` (Q, N), instantiated once on the operand registers.

Test Plan:
- Accumulate: count=2, pairs (0x0180, 0x0200) = 1.5×2.0 and (0x8100, 0x0080) = -1.0×0.5 → o_result=0x0280 (2.5), o_sat=0. o_valid rises 2 cycles after the second accept.
- Positive and negative saturation:
  - count=1, (0x7FFF, 0x7FFF) → 0x7FFF, o_sat=1.
  - count=1, (0xFFFF, 0x7FFF) → 0xFFFF, o_sat=1.
- Zero cases:
  - count=1, (0x8000, 0x0100) → 0x0000 (no -0), o_sat=0.
  - count=0 → 0x0000, o_sat=0, no o_ready pulse.
- Handshakes:
  - count=4 with i_valid gaps of 0/1/3 cycles → exactly 4 accepts; o_ready low after the 4th accept.
  - i_ready held low 5 cycles → o_valid and o_result stable throughout.
  - i_start asserted while busy → ignored.
- Reset mid-ACCUM: count=4, assert i_rst after 2 accepts → all outputs at reset values next cycle. A following count=1 with (0x0100, 0x0100) gives 0x0100.

Source files
------------

// File: rtl/neuron_pkg.sv
// neuron_pkg: types and helpers shared by the neuron datapath blocks.
//   N_DEF / Q_DEF : default operand width and fractional bits
//   MAG_MAX       : largest representable sign-magnitude magnitude
//   state_t       : MAC scheduler FSM states
//   sm_to_tc      : N-bit sign-magnitude -> (N+1)-bit two's complement
//   tc_to_sm      : (N+1)-bit two's complement -> N-bit sign-magnitude, saturating
package neuron_pkg;

  localparam int N_DEF   = 16;
  localparam int Q_DEF   = 8;
  localparam int MAG_MAX = (1 << (N_DEF - 1)) - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_OUTPUT
  } state_t;

  function automatic logic [N_DEF:0] sm_to_tc(input logic [N_DEF-1:0] sm);
    logic [N_DEF:0] mag;
    mag = {2'b00, sm[N_DEF-2:0]};
    return sm[N_DEF-1] ? -mag : mag;
  endfunction

  // Zero magnitude always yields a positive sign, so -0 is never produced.
  function automatic logic [N_DEF-1:0] tc_to_sm(input logic [N_DEF:0] tc);
    logic [N_DEF:0] mag;
    mag = tc[N_DEF] ? -tc : tc;
    if (mag > (N_DEF + 1)'(MAG_MAX)) mag = (N_DEF + 1)'(MAG_MAX);
    return {tc[N_DEF] & (|mag), mag[N_DEF-2:0]};
  endfunction

endpackage

// File: rtl/qmult.sv
// qmult: combinational sign-magnitude fixed-point multiplier.
//   i_multiplicand, i_multiplier : N-bit sign-magnitude, Q fractional bits
//   o_product : full product {sign, 2N-1 magnitude bits}, 2Q fractional bits
//   o_ovr     : product magnitude does not fit an N-bit Q-format result
module qmult #(
  parameter int Q = 8,
  parameter int N = 16
) (
  input  logic [N-1:0]   i_multiplicand,
  input  logic [N-1:0]   i_multiplier,
  output logic [2*N-1:0] o_product,
  output logic           o_ovr
);

  logic [2*N-3:0] w_mag;
  logic           w_sign;

  assign w_mag  = (2*N-2)'(i_multiplicand[N-2:0]) * (2*N-2)'(i_multiplier[N-2:0]);
  // A zero product is always +0, even when one operand is -0.
  assign w_sign = (i_multiplicand[N-1] ^ i_multiplier[N-1]) & (|w_mag);

  assign o_product = {w_sign, 1'b0, w_mag};
  assign o_ovr     = |w_mag[2*N-3:N-1+Q];

endmodule

// File: rtl/neuron_mac_scheduler.sv
// neuron_mac_scheduler: time-multiplexes one qmult over the input/weight
// pairs of a neuron, accumulates in two's complement, rescales by Q and
// returns a saturated N-bit sign-magnitude result.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_start, i_count  : start an evaluation of i_count pairs (clamped to MAX_TERMS)
//   o_busy            : not idle
//   i_valid/o_ready   : operand pair handshake (i_x, i_w)
//   o_valid/i_ready   : result handshake (o_result, o_sat)
module neuron_mac_scheduler
  import neuron_pkg::*;
#(
  parameter  int N         = N_DEF,
  parameter  int Q         = Q_DEF,
  parameter  int MAX_TERMS = 8,
  localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_count,
  output logic             o_busy,
  input  logic             i_valid,
  input  logic [N-1:0]     i_x,
  input  logic [N-1:0]     i_w,
  output logic             o_ready,
  output logic             o_valid,
  output logic [N-1:0]     o_result,
  output logic             o_sat,
  input  logic             i_ready
);

  localparam int ACC_W   = 2 * N + $clog2(MAX_TERMS) + 1;
  localparam int MAG_LIM = (1 << (N - 1)) - 1;

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_count, r_accepted;
  logic [N-1:0]      r_x, r_w;
  logic              r_op_vld;
  logic [ACC_W-1:0]  r_acc;
  logic [N-1:0]      r_result;
  logic              r_sat;

  logic              w_ready, w_valid, w_load_out, w_accept, w_start;
  logic [CNT_W-1:0]  w_count_clamped, w_accepted_inc;
  logic [2*N-1:0]    w_product;
  logic              w_unused_ovr;
  logic [ACC_W-1:0]  w_prod_mag, w_prod_tc;
  logic              w_acc_neg, w_over, w_res_sign;
  logic [ACC_W-1:0]  w_acc_abs, w_acc_shr;
  logic [N-2:0]      w_res_mag;

  qmult #(.Q(Q), .N(N)) u_qmult (
    .i_multiplicand (r_x),
    .i_multiplier   (r_w),
    .o_product      (w_product),
    .o_ovr          (w_unused_ovr)
  );

  assign w_count_clamped = (i_count > CNT_W'(MAX_TERMS)) ? CNT_W'(MAX_TERMS) : i_count;
  assign w_accepted_inc  = r_accepted + CNT_W'(1);
  assign w_accept        = i_valid & w_ready;
  assign w_start         = (r_state == ST_IDLE) & i_start;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_valid      = 1'b0;
    w_load_out   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_next = (w_count_clamped != '0) ? ST_ACCUM : ST_DRAIN;
      end
      ST_ACCUM: begin
        w_ready = (r_accepted < r_count);
        if (i_valid && w_ready && (w_accepted_inc == r_count)) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!r_op_vld) begin
          w_load_out   = 1'b1;
          w_state_next = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        w_valid = 1'b1;
        if (i_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Product stage: sign-magnitude product to two's complement.
  assign w_prod_mag = ACC_W'(w_product[2*N-2:0]);
  assign w_prod_tc  = w_product[2*N-1] ? -w_prod_mag : w_prod_mag;

  // Output stage: truncate magnitude toward zero, saturate, suppress -0.
  assign w_acc_neg  = r_acc[ACC_W-1];
  assign w_acc_abs  = w_acc_neg ? -r_acc : r_acc;
  assign w_acc_shr  = w_acc_abs >> Q;
  assign w_over     = (w_acc_shr > ACC_W'(MAG_LIM));
  assign w_res_mag  = w_over ? '1 : w_acc_shr[N-2:0];
  assign w_res_sign = w_acc_neg & (|w_res_mag);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count    <= '0;
      r_accepted <= '0;
      r_x        <= '0;
      r_w        <= '0;
      r_op_vld   <= 1'b0;
      r_acc      <= '0;
      r_result   <= '0;
      r_sat      <= 1'b0;
    end else begin
      r_op_vld <= w_accept;
      if (w_accept) begin
        r_x        <= i_x;
        r_w        <= i_w;
        r_accepted <= w_accepted_inc;
      end
      if (w_start) begin
        r_count    <= w_count_clamped;
        r_accepted <= '0;
        r_acc      <= '0;
      end else if (r_op_vld) begin
        r_acc <= r_acc + w_prod_tc;
      end
      if (w_load_out) begin
        r_result <= {w_res_sign, w_res_mag};
        r_sat    <= w_over;
      end
    end
  end

  assign o_busy   = (r_state != ST_IDLE);
  assign o_ready  = w_ready;
  assign o_valid  = w_valid;
  assign o_result = r_result;
  assign o_sat    = r_sat;

endmodule
